// File: rtl/hdbn_pkg.sv
// Shared symbol encoding for the HDBn chain: 00 zero, 01 mark, 10 violation (V), 11 balancing pulse (B).
package hdbn_pkg;

    localparam int CODE_W = 2;

    localparam logic [CODE_W-1:0] CODE_ZERO = 2'b00;
    localparam logic [CODE_W-1:0] CODE_ONE  = 2'b01;
    localparam logic [CODE_W-1:0] CODE_V    = 2'b10;
    localparam logic [CODE_W-1:0] CODE_B    = 2'b11;

endpackage

// File: rtl/hdbn_polarity.sv
// Output polarity stage: maps registered HDBn symbols to one-hot positive/negative line pulses.
// Instantiated by hdbn_sub_encoder only when HDBN_POLARITY_EN is defined.
module hdbn_polarity
    import hdbn_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_valid,
    input  logic [CODE_W-1:0] i_code,
    output logic              o_pos,
    output logic              o_neg
);

    logic r_last_pos;
    logic r_pos;
    logic r_neg;
    logic w_mark;
    logic w_pol_pos;

    // Marks and B alternate against the last pulse; V repeats it to flag the violation.
    always_comb begin
        w_mark    = 1'b0;
        w_pol_pos = r_last_pos;
        case (i_code)
            CODE_ONE, CODE_B: begin
                w_mark    = 1'b1;
                w_pol_pos = ~r_last_pos;
            end
            CODE_V: begin
                w_mark    = 1'b1;
                w_pol_pos = r_last_pos;
            end
            default: begin
                w_mark    = 1'b0;
                w_pol_pos = r_last_pos;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_pos <= 1'b0;
            r_pos      <= 1'b0;
            r_neg      <= 1'b0;
        end else if (i_clr) begin
            r_last_pos <= 1'b0;
            r_pos      <= 1'b0;
            r_neg      <= 1'b0;
        end else begin
            r_pos <= i_valid & w_mark & w_pol_pos;
            r_neg <= i_valid & w_mark & ~w_pol_pos;
            if (i_valid && w_mark) begin
                r_last_pos <= w_pol_pos;
            end
        end
    end

    assign o_pos = r_pos;
    assign o_neg = r_neg;

endmodule

// File: rtl/hdbn_sub_encoder.sv
// HDBn substitution encoder: codes each accepted bit, turns every run of N+1 zeros into B0..0V or 0..0V,
// and emits symbols N+2 accepted beats later. Define HDBN_POLARITY_EN to add the o_pos/o_neg line outputs.
module hdbn_sub_encoder
    import hdbn_pkg::*;
#(
    parameter int N               = 3,
    parameter bit INIT_PARITY_ODD = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_valid,
    input  logic              i_data,
    output logic              o_valid,
    output logic [CODE_W-1:0] o_code
`ifdef HDBN_POLARITY_EN
    ,
    output logic              o_pos,
    output logic              o_neg
`endif
);

    localparam int            ZW    = $clog2(N + 1);
    localparam logic [ZW-1:0] Z_MAX = ZW'(N);

    logic [N:0]               r_vld;
    logic [N+1:0][CODE_W-1:0] r_code;
    logic [ZW-1:0]            r_zcnt;
    logic                     r_parity;
    logic                     r_valid;

    logic                     w_accept;
    logic                     w_run_end;
    logic                     w_insert_b;
    logic                     w_out_valid;
    logic [CODE_W-1:0]        w_code_in;
    logic [ZW-1:0]            w_zcnt_next;
    logic                     w_parity_next;
    logic [N:0]               w_vld_next;
    logic [N+1:0][CODE_W-1:0] w_code_next;

    assign w_accept    = i_valid & ~i_clr;
    assign w_run_end   = ~i_data & (r_zcnt == Z_MAX);
    assign w_insert_b  = w_run_end & ~r_parity;
    assign w_out_valid = w_accept & r_vld[N];

    // A V clears parity, but an inserted B is itself a mark, so parity leaves a substituted run odd.
    always_comb begin
        w_code_in     = CODE_ZERO;
        w_zcnt_next   = r_zcnt + ZW'(1);
        w_parity_next = r_parity;
        if (i_data) begin
            w_code_in     = CODE_ONE;
            w_zcnt_next   = '0;
            w_parity_next = ~r_parity;
        end else if (w_run_end) begin
            w_code_in     = CODE_V;
            w_zcnt_next   = '0;
            w_parity_next = w_insert_b;
        end
    end

    // Stage N holds the first zero of the run at the moment its V enters stage 0.
    always_comb begin
        w_vld_next  = {r_vld[N-1:0], 1'b1};
        w_code_next = {r_code[N:0], w_code_in};
        if (w_insert_b) begin
            w_code_next[N] = CODE_B;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld    <= '0;
            r_code   <= '0;
            r_zcnt   <= '0;
            r_parity <= INIT_PARITY_ODD;
            r_valid  <= 1'b0;
        end else if (i_clr) begin
            r_vld    <= '0;
            r_code   <= '0;
            r_zcnt   <= '0;
            r_parity <= INIT_PARITY_ODD;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_out_valid;
            if (w_accept) begin
                r_vld    <= w_vld_next;
                r_code   <= w_code_next;
                r_zcnt   <= w_zcnt_next;
                r_parity <= w_parity_next;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_code  = r_code[N+1];

`ifdef HDBN_POLARITY_EN
    hdbn_polarity u_polarity (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_clr),
        .i_valid (w_out_valid),
        .i_code  (r_code[N]),
        .o_pos   (o_pos),
        .o_neg   (o_neg)
    );
`endif

endmodule

// File: tb/tb_hdbn_sub_encoder.sv
// Self-checking bench for hdbn_sub_encoder: N=3 and N=4 instances, expected symbols queued per beat.
// Polarity outputs are checked when HDBN_POLARITY_EN is defined.
`timescale 1ns/1ps
module tb_hdbn_sub_encoder;
    import hdbn_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       valid3 = 1'b0;
    logic       data3 = 1'b0;
    logic       valid4 = 1'b0;
    logic       data4 = 1'b0;
    logic       ov3;
    logic       ov4;
    logic [1:0] oc3;
    logic [1:0] oc4;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [1:0] q3[$];
    logic [1:0] q4[$];
    logic [1:0] hold3 = 2'b00;
    logic [1:0] mon_e3;
    logic [1:0] mon_e4;
    int         m_z3 = 0;
    logic       m_p3 = 1'b0;

`ifdef HDBN_POLARITY_EN
    logic       op3, on3, op4, on4;
    logic       last3 = 1'b0;
    logic       last4 = 1'b0;
    logic       pe_pos;
    logic [1:0] exp_pn;
`endif

    always #5 clk = ~clk;

    hdbn_sub_encoder #(.N(3), .INIT_PARITY_ODD(1'b0)) u_dut3 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (clr),
        .i_valid (valid3),
        .i_data  (data3),
        .o_valid (ov3),
        .o_code  (oc3)
`ifdef HDBN_POLARITY_EN
        ,
        .o_pos   (op3),
        .o_neg   (on3)
`endif
    );

    hdbn_sub_encoder #(.N(4), .INIT_PARITY_ODD(1'b0)) u_dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (clr),
        .i_valid (valid4),
        .i_data  (data4),
        .o_valid (ov4),
        .o_code  (oc4)
`ifdef HDBN_POLARITY_EN
        ,
        .o_pos   (op4),
        .o_neg   (on4)
`endif
    );

    // Scoreboard: every valid output pops the oldest expected symbol.
    always @(negedge clk) begin
        if (rst_n && ov3) begin
            n_checks++;
            if (q3.size() == 0) begin
                $display("[TB] FAIL dut3_code: got %b, expected nothing (queue empty)", oc3);
            end else begin
                mon_e3 = q3.pop_front();
                hold3  = mon_e3;
                if (oc3 !== mon_e3) $display("[TB] FAIL dut3_code: got %b, expected %b", oc3, mon_e3);
                else n_pass++;
`ifdef HDBN_POLARITY_EN
                pe_pos = (mon_e3 == CODE_V) ? last3 : ~last3;
                exp_pn = (mon_e3 == CODE_ZERO) ? 2'b00 : {pe_pos, ~pe_pos};
                if (mon_e3 != CODE_ZERO) last3 = pe_pos;
                n_checks++;
                if ({op3, on3} !== exp_pn) $display("[TB] FAIL dut3_pol: got pos/neg %b, expected %b", {op3, on3}, exp_pn);
                else n_pass++;
`endif
            end
        end
        if (rst_n && ov4) begin
            n_checks++;
            if (q4.size() == 0) begin
                $display("[TB] FAIL dut4_code: got %b, expected nothing (queue empty)", oc4);
            end else begin
                mon_e4 = q4.pop_front();
                if (oc4 !== mon_e4) $display("[TB] FAIL dut4_code: got %b, expected %b", oc4, mon_e4);
                else n_pass++;
`ifdef HDBN_POLARITY_EN
                pe_pos = (mon_e4 == CODE_V) ? last4 : ~last4;
                exp_pn = (mon_e4 == CODE_ZERO) ? 2'b00 : {pe_pos, ~pe_pos};
                if (mon_e4 != CODE_ZERO) last4 = pe_pos;
                n_checks++;
                if ({op4, on4} !== exp_pn) $display("[TB] FAIL dut4_pol: got pos/neg %b, expected %b", {op4, on4}, exp_pn);
                else n_pass++;
`endif
            end
        end
    end

    function automatic logic [1:0] code_of(input byte c);
        case (c)
            "1":     code_of = CODE_ONE;
            "V":     code_of = CODE_V;
            "B":     code_of = CODE_B;
            default: code_of = CODE_ZERO;
        endcase
    endfunction

    task automatic reset_models();
        q3.delete();
        q4.delete();
        hold3 = 2'b00;
        m_z3  = 0;
        m_p3  = 1'b0;
`ifdef HDBN_POLARITY_EN
        last3 = 1'b0;
        last4 = 1'b0;
`endif
    endtask

    // All drive tasks start and end one time unit after a rising edge.
    task automatic beat3(input logic d, input logic [1:0] e);
        valid3 = 1'b1;
        data3  = d;
        q3.push_back(e);
        @(posedge clk);
        #1;
        valid3 = 1'b0;
    endtask

    task automatic beat4(input logic d, input logic [1:0] e);
        valid4 = 1'b1;
        data4  = d;
        q4.push_back(e);
        @(posedge clk);
        #1;
        valid4 = 1'b0;
    endtask

    task automatic run3(input string s);
        for (int i = 0; i < s.len(); i++) begin
            byte c = s[i];
            beat3(c == "1", code_of(c));
        end
    endtask

    task automatic do_clear();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        reset_models();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        reset_models();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks += 4;
        if (ov3 !== 1'b0) $display("[TB] FAIL reset_valid3: got %b, expected 0", ov3); else n_pass++;
        if (oc3 !== 2'b00) $display("[TB] FAIL reset_code3: got %b, expected 00", oc3); else n_pass++;
        if (ov4 !== 1'b0) $display("[TB] FAIL reset_valid4: got %b, expected 0", ov4); else n_pass++;
        if (oc4 !== 2'b00) $display("[TB] FAIL reset_code4: got %b, expected 00", oc4); else n_pass++;
`ifdef HDBN_POLARITY_EN
        n_checks++;
        if ({op3, on3, op4, on4} !== 4'b0000) $display("[TB] FAIL reset_pol: got %b, expected 0000", {op3, on3, op4, on4});
        else n_pass++;
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_zero_runs();
        run3("B00V000V1111");
        @(negedge clk);
        #1;
        n_checks++;
        if (q3.size() != 4) $display("[TB] FAIL zero_runs_count: got %0d pending, expected 4", q3.size()); else n_pass++;
        do_clear();
        @(negedge clk);
        #1;
        n_checks += 2;
        if (ov3 !== 1'b0) $display("[TB] FAIL clear_valid: got %b, expected 0", ov3); else n_pass++;
        if (oc3 !== 2'b00) $display("[TB] FAIL clear_code: got %b, expected 00", oc3); else n_pass++;
    endtask

    task automatic test_marks();
        run3("1000V11B00V1111");
        @(negedge clk);
        #1;
        n_checks++;
        if (q3.size() != 4) $display("[TB] FAIL marks_count: got %0d pending, expected 4", q3.size()); else n_pass++;
        do_clear();
    endtask

    task automatic test_n4_latency();
        string s = "B000V11111";
        for (int k = 0; k < s.len(); k++) begin
            byte c = s[k];
            beat4(c == "1", code_of(c));
            @(negedge clk);
            #1;
            n_checks++;
            if (ov4 !== (k >= 5)) $display("[TB] FAIL n4_latency beat %0d: got o_valid %b, expected %b", k + 1, ov4, (k >= 5));
            else n_pass++;
        end
        n_checks++;
        if (q4.size() != 5) $display("[TB] FAIL n4_count: got %0d pending, expected 5", q4.size()); else n_pass++;
        do_clear();
    endtask

    task automatic test_gaps();
        string s = "1000V1111";
        for (int k = 0; k < s.len(); k++) begin
            byte c = s[k];
            beat3(c == "1", code_of(c));
            @(posedge clk);
            #1;
            @(negedge clk);
            #1;
            n_checks += 2;
            if (ov3 !== 1'b0) $display("[TB] FAIL gap_valid beat %0d: got %b, expected 0", k + 1, ov3); else n_pass++;
            if (oc3 !== hold3) $display("[TB] FAIL gap_hold beat %0d: got %b, expected %b", k + 1, oc3, hold3); else n_pass++;
        end
        n_checks++;
        if (q3.size() != 4) $display("[TB] FAIL gaps_count: got %0d pending, expected 4", q3.size()); else n_pass++;
        do_clear();
    endtask

    task automatic test_clear_midrun();
        run3("000");
        valid3 = 1'b1;
        data3  = 1'b0;
        clr    = 1'b1;
        @(posedge clk);
        #1;
        clr    = 1'b0;
        valid3 = 1'b0;
        reset_models();
        @(negedge clk);
        #1;
        n_checks += 2;
        if (ov3 !== 1'b0) $display("[TB] FAIL clrmid_valid: got %b, expected 0", ov3); else n_pass++;
        if (oc3 !== 2'b00) $display("[TB] FAIL clrmid_code: got %b, expected 00", oc3); else n_pass++;
        run3("B00V1111");
        @(negedge clk);
        #1;
        n_checks++;
        if (q3.size() != 4) $display("[TB] FAIL clrmid_count: got %0d pending, expected 4", q3.size()); else n_pass++;
        do_clear();
    endtask

    task automatic test_reset_midstream();
        run3("1000V1");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        n_checks += 2;
        if (ov3 !== 1'b0) $display("[TB] FAIL rstmid_valid: got %b, expected 0", ov3); else n_pass++;
        if (oc3 !== 2'b00) $display("[TB] FAIL rstmid_code: got %b, expected 00", oc3); else n_pass++;
        reset_models();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run3("B00V1111");
        @(negedge clk);
        #1;
        n_checks++;
        if (q3.size() != 4) $display("[TB] FAIL rstmid_count: got %0d pending, expected 4", q3.size()); else n_pass++;
        do_clear();
    endtask

    // Random stream with gaps; expected symbols come from a bench-side model of the substitution rule.
    task automatic test_random();
        logic       d;
        logic [1:0] e;
        for (int i = 0; i < 304; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            d = (i >= 300) ? 1'b1 : ($urandom_range(0, 2) == 0);
            if (d) begin
                e    = CODE_ONE;
                m_z3 = 0;
                m_p3 = ~m_p3;
            end else if (m_z3 == 3) begin
                e    = CODE_V;
                m_z3 = 0;
                if (!m_p3) begin
                    q3[$-2] = CODE_B;
                    m_p3    = 1'b1;
                end else begin
                    m_p3 = 1'b0;
                end
            end else begin
                e    = CODE_ZERO;
                m_z3 = m_z3 + 1;
            end
            beat3(d, e);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (q3.size() != 4) $display("[TB] FAIL random_count: got %0d pending, expected 4", q3.size()); else n_pass++;
        do_clear();
    endtask

`ifdef HDBN_POLARITY_EN
    task automatic test_polarity();
        run3("1000VB00V1111");
        @(negedge clk);
        #1;
        n_checks++;
        if (q3.size() != 4) $display("[TB] FAIL polarity_count: got %0d pending, expected 4", q3.size()); else n_pass++;
        do_clear();
    endtask
`endif

    initial begin
        test_reset();
        test_zero_runs();
        test_marks();
        test_n4_latency();
        test_gaps();
        test_clear_midrun();
        test_reset_midstream();
`ifdef HDBN_POLARITY_EN
        test_polarity();
`endif
        test_random();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
